// File: rtl/mem_check_pkg.sv
// Shared types and helpers for the data-memory store-sequence checker.
// States, store-size encodings (same as the core's memwrite strobe) and
// the byte-lane compare mask used when matching a store against an entry.
package mem_check_pkg;

    // Checker life cycle: load expectations, compare, then a terminal verdict.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } chk_state_t;

    // Store size encoding shared by memwrite and the expected entries.
    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    // Widest data bus the mask helper can describe; DW must not exceed it.
    localparam int MAX_DW = 512;

    // Bits of writedata that take part in the compare for a given size.
    // Byte and halfword stores only drive the low lanes; a word compares
    // the whole bus. Callers zero-extend both operands to MAX_DW.
    function automatic logic [MAX_DW-1:0] size_mask(input logic [1:0] size);
        logic [MAX_DW-1:0] m;
        m = '0;
        case (size)
            SZ_BYTE: m[7:0]  = '1;
            SZ_HALF: m[15:0] = '1;
            SZ_WORD: m       = '1;
            default: m       = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/store_exp_fifo.sv
// Queue of expected stores for mem_store_checker.
// Plain synchronous FIFO with a look-ahead head output, so the checker can
// compare a monitored store against the oldest entry in the same cycle.
// Pointers carry one extra wrap bit; occupancy is their difference.
module store_exp_fifo
    import mem_check_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 66
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [W-1:0]             din_i,
    input  logic                     pop_i,
    output logic [W-1:0]             head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [PW:0]  wr_q, wr_d;
    logic [PW:0]  rd_q, rd_d;
    logic         push_ok;
    logic         pop_ok;

    assign count_o = wr_q - rd_q;
    assign full_o  = (count_o == (PW+1)'(DEPTH));
    assign empty_o = (wr_q == rd_q);
    assign head_o  = mem_q[rd_q[PW-1:0]];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Pointer advance; overflow and underflow requests are dropped.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_ok) wr_d = wr_q + (PW+1)'(1);
        if (pop_ok)  rd_d = rd_q + (PW+1)'(1);
    end

    // Pointer registers; reset discards any queued entries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Entry storage; contents are only meaningful between rd and wr.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[PW-1:0]] <= din_i;
    end

endmodule

// File: rtl/mem_store_checker.sv
// Ordered, size-aware checker for the MIPS core's data-memory write bus.
// Expected stores are loaded in IDLE, then every monitored store in RUN is
// compared against the oldest expected entry. The verdict (PASS / FAIL) is
// terminal until reset. dbg_state_o exposes the FSM state for checkers.
// Optional: define MEM_STORE_CHECKER_TIMEOUT_EN to fail a RUN that sees no
// store for TIMEOUT consecutive cycles; otherwise RUN may wait forever.
//
// Handshake: an expected entry is taken on a rising clk edge where
// exp_valid && exp_ready are both high; exp_valid may be held or dropped
// freely, exp_ready is high only in IDLE with room in the queue.
module mem_store_checker
    import mem_check_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       exp_valid,
    output logic                       exp_ready,
    input  logic [AW-1:0]              exp_addr,
    input  logic [DW-1:0]              exp_data,
    input  logic [1:0]                 exp_size,
    input  logic                       start,
    input  logic [1:0]                 memwrite,
    input  logic [AW-1:0]              dataadr,
    input  logic [DW-1:0]              writedata,
    output logic                       done,
    output logic                       pass,
    output logic                       fail,
    output logic [$clog2(DEPTH)-1:0]   fail_idx,
    output logic [$clog2(DEPTH):0]     checked_cnt,
    output logic                       timeout,
    output chk_state_t                 dbg_state_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam int EW = AW + DW + 2;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DW < 32 || (DW % 8) != 0 ||
        DW > MAX_DW || TIMEOUT < 1) begin : g_bad_params
        $error("mem_store_checker: unsupported DEPTH/DW/TIMEOUT combination");
    end

    chk_state_t      state_q, state_d;
    logic [CW-1:0]   checked_q, checked_d;
    logic [IW-1:0]   fail_idx_q, fail_idx_d;
    logic            exp_ready_q, exp_ready_d;
    logic            done_q, pass_q, fail_q;

    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [EW-1:0]   fifo_head;
    logic [AW-1:0]   head_addr;
    logic [DW-1:0]   head_data;
    logic [1:0]      head_size;

    logic              store_seen;
    logic [MAX_DW-1:0] data_diff;
    logic              entry_match;

    // exp_ready_q is only ever high in IDLE, so pushes happen only there.
    assign push = exp_valid && exp_ready_q;

    store_exp_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .din_i   ({exp_addr, exp_data, exp_size}),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign {head_addr, head_data, head_size} = fifo_head;

    // Zero-latency compare of the bus against the head entry. Only the lanes
    // a store of the expected size drives take part in the data compare.
    assign store_seen  = (memwrite != SZ_NONE);
    assign data_diff   = (MAX_DW'(writedata) ^ MAX_DW'(head_data)) & size_mask(head_size);
    assign entry_match = store_seen && (dataadr == head_addr) &&
                         (memwrite == head_size) && (data_diff == '0);

`ifdef MEM_STORE_CHECKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] idle_q, idle_d;
    logic          idle_hit;
    logic          timeout_q, timeout_d;

    // idle_q counts completed store-free RUN cycles; the TIMEOUT-th one fails.
    assign idle_hit = (idle_q == TW'(TIMEOUT - 1));

    // Idle counter runs only in RUN and restarts on any store or RUN entry.
    always_comb begin
        idle_d = '0;
        if (state_q == RUN && !store_seen) idle_d = idle_q + TW'(1);
    end

    // Idle counter and timeout flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // Next-state logic: load, compare in order, latch the first error.
    always_comb begin
        state_d    = state_q;
        checked_d  = checked_q;
        fail_idx_d = fail_idx_q;
        pop        = 1'b0;
`ifdef MEM_STORE_CHECKER_TIMEOUT_EN
        timeout_d  = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                // An entry pushed with start counts toward the empty test.
                if (start) state_d = (fifo_empty && !push) ? PASS : RUN;
            end
            RUN: begin
                if (store_seen) begin
                    if (entry_match) begin
                        pop       = 1'b1;
                        checked_d = checked_q + CW'(1);
                        if (fifo_count == CW'(1)) state_d = PASS;
                    end else begin
                        state_d    = FAIL;
                        fail_idx_d = checked_q[IW-1:0];
                    end
                end
`ifdef MEM_STORE_CHECKER_TIMEOUT_EN
                else if (idle_hit) begin
                    state_d    = FAIL;
                    fail_idx_d = checked_q[IW-1:0];
                    timeout_d  = 1'b1;
                end
`endif
            end
            PASS: begin
                // Any store after the last expected one is an extra store.
                if (store_seen) begin
                    state_d    = FAIL;
                    fail_idx_d = checked_q[IW-1:0];
                end
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ready for the next cycle: still loading and the queue not filled now.
    assign exp_ready_d = (state_d == IDLE) && !fifo_full &&
                         !(push && fifo_count == CW'(DEPTH - 1));

    // State and registered outputs, all derived from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            checked_q   <= '0;
            fail_idx_q  <= '0;
            exp_ready_q <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            checked_q   <= checked_d;
            fail_idx_q  <= fail_idx_d;
            exp_ready_q <= exp_ready_d;
            done_q      <= (state_d == PASS) || (state_d == FAIL);
            pass_q      <= (state_d == PASS);
            fail_q      <= (state_d == FAIL);
        end
    end

    assign exp_ready   = exp_ready_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign fail_idx    = fail_idx_q;
    assign checked_cnt = checked_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_store_checker.sv
// Bench for mem_store_checker: directed scenarios plus randomized runs
// checked against a queue-based model of the checker's rules.
// Build with MEM_STORE_CHECKER_TIMEOUT_EN to exercise the idle timeout.
module tb_mem_store_checker;
    import mem_check_pkg::*;

    localparam int DEPTH      = 8;
    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int TB_TIMEOUT = 16;

    localparam int M_LOAD = 0;
    localparam int M_RUN  = 1;
    localparam int M_PASS = 2;
    localparam int M_FAIL = 3;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    size;
    } ent_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          exp_valid = 1'b0;
    logic          exp_ready;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_data = '0;
    logic [1:0]    exp_size = '0;
    logic          start = 1'b0;
    logic [1:0]    memwrite = '0;
    logic [AW-1:0] dataadr = '0;
    logic [DW-1:0] writedata = '0;
    logic          done, pass, fail, timeout;
    logic [2:0]    fail_idx;
    logic [3:0]    checked_cnt;
    chk_state_t    dbg_state;

    mem_store_checker #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .exp_valid   (exp_valid),
        .exp_ready   (exp_ready),
        .exp_addr    (exp_addr),
        .exp_data    (exp_data),
        .exp_size    (exp_size),
        .start       (start),
        .memwrite    (memwrite),
        .dataadr     (dataadr),
        .writedata   (writedata),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .fail_idx    (fail_idx),
        .checked_cnt (checked_cnt),
        .timeout     (timeout),
        .dbg_state_o (dbg_state)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    ent_t exp_q[$];
    int   m_mode;
    int   m_cnt;
    int   m_idx;
    int   m_idle;
    bit   m_tmo;

    function automatic bit store_ok(ent_t e, logic [AW-1:0] a, logic [DW-1:0] d, logic [1:0] s);
        if (a != e.addr || s != e.size) return 1'b0;
        if (s == 2'd1) return (d % 256) == (e.data % 256);
        if (s == 2'd2) return (d % 65536) == (e.data % 65536);
        return d == e.data;
    endfunction

    function automatic chk_state_t model_state();
        case (m_mode)
            M_RUN:   return RUN;
            M_PASS:  return PASS;
            M_FAIL:  return FAIL;
            default: return IDLE;
        endcase
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_mode = M_LOAD;
        m_cnt  = 0;
        m_idx  = 0;
        m_idle = 0;
        m_tmo  = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit   rdy;
        ent_t e;
        rdy = (m_mode == M_LOAD) && (exp_q.size() < DEPTH);
        case (m_mode)
            M_LOAD: begin
                if (exp_valid && rdy) begin
                    e.addr = exp_addr;
                    e.data = exp_data;
                    e.size = exp_size;
                    exp_q.push_back(e);
                end
                if (start) begin
                    m_mode = (exp_q.size() == 0) ? M_PASS : M_RUN;
                    m_idle = 0;
                end
            end
            M_RUN: begin
                if (memwrite != 2'd0) begin
                    m_idle = 0;
                    if (store_ok(exp_q[0], dataadr, writedata, memwrite)) begin
                        void'(exp_q.pop_front());
                        m_cnt++;
                        if (exp_q.size() == 0) m_mode = M_PASS;
                    end else begin
                        m_mode = M_FAIL;
                        m_idx  = m_cnt % DEPTH;
                    end
                end else begin
`ifdef MEM_STORE_CHECKER_TIMEOUT_EN
                    m_idle++;
                    if (m_idle >= TB_TIMEOUT) begin
                        m_mode = M_FAIL;
                        m_tmo  = 1'b1;
                        m_idx  = m_cnt % DEPTH;
                    end
`endif
                end
            end
            M_PASS: begin
                if (memwrite != 2'd0) begin
                    m_mode = M_FAIL;
                    m_idx  = m_cnt % DEPTH;
                end
            end
            default: ;
        endcase
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        exp_valid = 1'b0;
        start     = 1'b0;
        memwrite  = 2'd0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        drive_idle();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic push_entry(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] s);
        exp_valid = 1'b1;
        exp_addr  = a;
        exp_data  = d;
        exp_size  = s;
        tick();
        exp_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] s);
        memwrite  = s;
        dataadr   = a;
        writedata = d;
        tick();
        memwrite  = 2'd0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        n_vec++; if (exp_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0b want 1", exp_ready); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b want 0", done); end
        n_vec++; if (pass !== 1'b0) begin n_err++; $display("FAIL reset_pass: got %0b want 0", pass); end
        n_vec++; if (fail !== 1'b0) begin n_err++; $display("FAIL reset_fail: got %0b want 0", fail); end
        n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %0b want 0", timeout); end
        n_vec++; if (fail_idx !== 3'd0) begin n_err++; $display("FAIL reset_fail_idx: got %0d want 0", fail_idx); end
        n_vec++; if (checked_cnt !== 4'd0) begin n_err++; $display("FAIL reset_checked: got %0d want 0", checked_cnt); end
        n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
    endtask

    task automatic test_single();
        apply_reset();
        push_entry(32'd84, 32'd7, SZ_WORD);
        do_start();
        n_vec++; if (done !== 1'b0 || dbg_state !== RUN) begin n_err++; $display("FAIL single_run: got done=%0b state=%0d want done=0 RUN", done, dbg_state); end
        do_store(32'd84, 32'd7, SZ_WORD);
        n_vec++; if (pass !== 1'b1 || done !== 1'b1 || fail !== 1'b0) begin n_err++; $display("FAIL single_pass: got pass=%0b done=%0b fail=%0b want 1 1 0", pass, done, fail); end
        n_vec++; if (checked_cnt !== 4'd1) begin n_err++; $display("FAIL single_checked: got %0d want 1", checked_cnt); end
    endtask

    task automatic load_three();
        apply_reset();
        push_entry(32'h50, 32'h11, SZ_BYTE);
        push_entry(32'h54, 32'h1234, SZ_HALF);
        push_entry(32'h58, 32'hDEADBEEF, SZ_WORD);
        do_start();
    endtask

    task automatic test_sized_pass();
        load_three();
        do_store(32'h50, 32'hFFFFFF11, SZ_BYTE);
        n_vec++; if (checked_cnt !== 4'd1 || done !== 1'b0) begin n_err++; $display("FAIL sized_first: got cnt=%0d done=%0b want 1 0", checked_cnt, done); end
        do_store(32'h54, 32'hFFFF1234, SZ_HALF);
        do_store(32'h58, 32'hDEADBEEF, SZ_WORD);
        n_vec++; if (pass !== 1'b1 || fail !== 1'b0) begin n_err++; $display("FAIL sized_pass: got pass=%0b fail=%0b want 1 0", pass, fail); end
        n_vec++; if (checked_cnt !== 4'd3) begin n_err++; $display("FAIL sized_checked: got %0d want 3", checked_cnt); end
    endtask

    task automatic test_data_mismatch();
        load_three();
        do_store(32'h50, 32'hFFFFFF11, SZ_BYTE);
        do_store(32'h54, 32'hFFFF1235, SZ_HALF);
        n_vec++; if (fail !== 1'b1 || pass !== 1'b0 || done !== 1'b1) begin n_err++; $display("FAIL mism_flags: got fail=%0b pass=%0b done=%0b want 1 0 1", fail, pass, done); end
        n_vec++; if (fail_idx !== 3'd1) begin n_err++; $display("FAIL mism_idx: got %0d want 1", fail_idx); end
        // A later correct store must not revive the run.
        do_store(32'h58, 32'hDEADBEEF, SZ_WORD);
        n_vec++; if (checked_cnt !== 4'd1 || fail !== 1'b1 || pass !== 1'b0) begin n_err++; $display("FAIL mism_sticky: got cnt=%0d fail=%0b pass=%0b want 1 1 0", checked_cnt, fail, pass); end
    endtask

    task automatic test_full_extra();
        ent_t e [DEPTH];
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            e[i].addr = 32'h1000 + 32'(4 * i);
            e[i].data = $urandom;
            e[i].size = 2'($urandom_range(1, 3));
            push_entry(e[i].addr, e[i].data, e[i].size);
            if (i == DEPTH - 2) begin
                n_vec++; if (exp_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_7: got %0b want 1", exp_ready); end
            end
        end
        n_vec++; if (exp_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_8: got %0b want 0", exp_ready); end
        push_entry(32'hBAD0, 32'hBAD0, SZ_WORD);  // refused: queue full
        do_start();
        for (int i = 0; i < DEPTH; i++) do_store(e[i].addr, e[i].data, e[i].size);
        n_vec++; if (pass !== 1'b1 || checked_cnt !== 4'd8) begin n_err++; $display("FAIL full_pass: got pass=%0b cnt=%0d want 1 8", pass, checked_cnt); end
        do_store(32'h2000, 32'h1, SZ_WORD);
        n_vec++; if (fail !== 1'b1 || pass !== 1'b0 || fail_idx !== 3'd0) begin n_err++; $display("FAIL extra_store: got fail=%0b pass=%0b idx=%0d want 1 0 0", fail, pass, fail_idx); end
        n_vec++; if (checked_cnt !== 4'd8) begin n_err++; $display("FAIL extra_checked: got %0d want 8", checked_cnt); end
    endtask

    task automatic test_reset_mid_run();
        apply_reset();
        push_entry(32'h100, 32'hA5, SZ_BYTE);
        push_entry(32'h104, 32'h5A5A, SZ_HALF);
        do_start();
        do_store(32'h100, 32'h000000A5, SZ_BYTE);
        n_vec++; if (checked_cnt !== 4'd1 || dbg_state !== RUN) begin n_err++; $display("FAIL midrst_pre: got cnt=%0d state=%0d want 1 RUN", checked_cnt, dbg_state); end
        #3;
        reset = 1'b1;
        #1;
        n_vec++; if (done !== 1'b0 || pass !== 1'b0 || fail !== 1'b0 || timeout !== 1'b0) begin n_err++; $display("FAIL midrst_flags: got %0b%0b%0b%0b want 0000", done, pass, fail, timeout); end
        n_vec++; if (checked_cnt !== 4'd0 || fail_idx !== 3'd0) begin n_err++; $display("FAIL midrst_counts: got cnt=%0d idx=%0d want 0 0", checked_cnt, fail_idx); end
        n_vec++; if (exp_ready !== 1'b1 || dbg_state !== IDLE) begin n_err++; $display("FAIL midrst_idle: got ready=%0b state=%0d want 1 IDLE", exp_ready, dbg_state); end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        do_start();
        n_vec++; if (pass !== 1'b1 || done !== 1'b1 || checked_cnt !== 4'd0) begin n_err++; $display("FAIL midrst_empty: got pass=%0b done=%0b cnt=%0d want 1 1 0", pass, done, checked_cnt); end
    endtask

    task automatic test_timeout();
        apply_reset();
        push_entry(32'h40, 32'h99, SZ_WORD);
        do_start();
`ifdef MEM_STORE_CHECKER_TIMEOUT_EN
        for (int i = 0; i < TB_TIMEOUT - 1; i++) tick();
        n_vec++; if (fail !== 1'b0 || timeout !== 1'b0) begin n_err++; $display("FAIL tmo_early: got fail=%0b timeout=%0b want 0 0", fail, timeout); end
        tick();
        n_vec++; if (fail !== 1'b1 || timeout !== 1'b1 || fail_idx !== 3'd0) begin n_err++; $display("FAIL tmo_hit: got fail=%0b timeout=%0b idx=%0d want 1 1 0", fail, timeout, fail_idx); end
`else
        for (int i = 0; i < 3 * TB_TIMEOUT; i++) tick();
        n_vec++; if (fail !== 1'b0 || timeout !== 1'b0 || dbg_state !== RUN) begin n_err++; $display("FAIL tmo_wait: got fail=%0b timeout=%0b state=%0d want 0 0 RUN", fail, timeout, dbg_state); end
        do_store(32'h40, 32'h99, SZ_WORD);
        n_vec++; if (pass !== 1'b1) begin n_err++; $display("FAIL tmo_late_pass: got %0b want 1", pass); end
`endif
    endtask

    task automatic test_random();
        for (int r = 0; r < 10; r++) begin
            int n;
            int pushed;
            apply_reset();
            n = $urandom_range(0, DEPTH);
            pushed = 0;
            for (int c = 0; c < 40; c++) begin
                logic [31:0] rv;
                ent_t        e;
                drive_idle();
                rv = $urandom;
                if (m_mode == M_LOAD) begin
                    exp_valid = (pushed < n) && ($urandom_range(0, 3) != 0);
                    exp_addr  = 32'h3000 + 32'($urandom_range(0, 15) * 4);
                    exp_data  = $urandom;
                    exp_size  = 2'($urandom_range(1, 3));
                    start     = ((pushed + (exp_valid ? 1 : 0)) >= n) && ($urandom_range(0, 1) == 1);
                    if (exp_valid) pushed++;
                    // Stray stores while loading must be ignored.
                    if ($urandom_range(0, 4) == 0) begin
                        memwrite  = 2'($urandom_range(1, 3));
                        dataadr   = $urandom;
                        writedata = $urandom;
                    end
                end else if ($urandom_range(0, 2) != 0) begin
                    if (m_mode == M_RUN) begin
                        e = exp_q[0];
                        if (e.size == SZ_BYTE) e.data = {rv[31:8], e.data[7:0]};
                        else if (e.size == SZ_HALF) e.data = {rv[31:16], e.data[15:0]};
                        if ($urandom_range(0, 5) == 0) begin
                            case ($urandom_range(0, 2))
                                0:       e.addr = e.addr ^ 32'h4;
                                1:       e.data = e.data ^ 32'h1;
                                default: e.size = (e.size == SZ_WORD) ? SZ_BYTE : e.size + 2'd1;
                            endcase
                        end
                    end else begin
                        e.addr = $urandom;
                        e.data = rv;
                        e.size = 2'($urandom_range(1, 3));
                    end
                    memwrite  = e.size;
                    dataadr   = e.addr;
                    writedata = e.data;
                end
                tick();
                n_vec++; if (exp_ready !== ((m_mode == M_LOAD) && (exp_q.size() < DEPTH))) begin n_err++; $display("FAIL rnd_ready r%0d c%0d: got %0b", r, c, exp_ready); end
                n_vec++; if (done !== (m_mode == M_PASS || m_mode == M_FAIL)) begin n_err++; $display("FAIL rnd_done r%0d c%0d: got %0b", r, c, done); end
                n_vec++; if (pass !== (m_mode == M_PASS)) begin n_err++; $display("FAIL rnd_pass r%0d c%0d: got %0b", r, c, pass); end
                n_vec++; if (fail !== (m_mode == M_FAIL)) begin n_err++; $display("FAIL rnd_fail r%0d c%0d: got %0b", r, c, fail); end
                n_vec++; if (fail_idx !== 3'(m_idx)) begin n_err++; $display("FAIL rnd_idx r%0d c%0d: got %0d want %0d", r, c, fail_idx, m_idx); end
                n_vec++; if (checked_cnt !== 4'(m_cnt)) begin n_err++; $display("FAIL rnd_checked r%0d c%0d: got %0d want %0d", r, c, checked_cnt, m_cnt); end
                n_vec++; if (timeout !== m_tmo) begin n_err++; $display("FAIL rnd_timeout r%0d c%0d: got %0b want %0b", r, c, timeout, m_tmo); end
                n_vec++; if (dbg_state !== model_state()) begin n_err++; $display("FAIL rnd_state r%0d c%0d: got %0d want %0d", r, c, dbg_state, model_state()); end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        model_reset();
        test_reset();
        test_single();
        test_sized_pass();
        test_data_mismatch();
        test_full_extra();
        test_reset_mid_run();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
